instr_encoder: RTL
==================

# instr_encoder

Streaming RV32 instruction encoder, the inverse of the core's immediate decoder: accepts field-level requests (opcode, registers, functs, 32-bit immediate) over a valid/ready handshake and emits packed 32-bit instruction words. Multi-word cases are sequenced by an FSM:

- the two-word FLI format;
- the LI pseudo-op (LUI+ADDI split).

It sits between the on-chip loader/test-program generator and instruction memory.

## Interface
Parameters:
- none; all encodings come from `isa_pkg`.

Ports:
- `clk`  in  1  system clock
- `rstn`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_opcode`  in  7  target opcode (`isa_pkg` values)
- `req_li`  in  1  LI pseudo-op; `req_opcode` ignored
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register fields
- `req_funct3`  in  3
- `req_funct7`  in  7
- `req_imm`  in  32  immediate, byte-offset/value as seen by the decoder
- `out_valid`  out  1  word present
- `out_ready`  in  1  word consumed when `out_valid && out_ready`
- `out_instr`  out  32  encoded word
- `out_last`  out  1  final word of the request
- `out_err`  out  1  immediate out of range or misaligned for the format; word still emitted, truncated

## Operation
Formats per opcode:
- **U**: LUI, AUIPC.
- **J**: JAL.
- **I**: JALR, LOAD, CALCI, FLOAD, VLW, VSW.
- **S**: STORE, FSTORE.
- **B**: BRANCH, FBRANCH.
- **R**: CALC, F. Immediate ignored.
- Unknown opcodes encode as R, with `out_err`=1.

Field placement is the exact inverse of the decoder (e.g. B: `imm[12]`→31, `imm[10:5]`→30:25, `imm[4:1]`→11:8, `imm[11]`→7).

Range checks, which drive `out_err`:
- I/S: imm in [-2048, 2047].
- B: imm in [-4096, 4094] and `imm[0]`=0.
- J: imm in [-2^20, 2^20-2] and `imm[0]`=0.
- U: `imm[11:0]`=0.

FLI (two words):
- Word 0 = `{imm[31:12], rd, FLI}`.
- Word 1 = `{8'h00, imm[11:0], 12'h000}`; `out_last` on word 1 only.

LI (`req_li`=1):
- If imm sign-fits 12 bits: single `ADDI rd, x0, imm`.
- Otherwise, `hi = imm[31:12] + imm[11]` (mod 2^20), then two words:
  - `LUI rd, hi<<12`;
  - `ADDI rd, rd, imm[11:0]`.
- `rd`=0 is legal and encoded as-is.

FSM:
- **IDLE**: output empty.
- **EMIT0**: first/only word held.
- **EMIT1**: second word held.

Transitions:
- IDLE → EMIT0 on accept.
- EMIT0 → EMIT1 on consume if two-word.
- EMIT0 → IDLE on consume if single-word and no new accept.
- EMIT0 → EMIT0 on consume if single-word with a simultaneous accept.
- EMIT1 → IDLE on consume, or → EMIT0 on consume with a simultaneous accept.

Second-word fields come from a request latch captured at accept; the request inputs are not re-read after accept.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_last`=0, `out_err`=0, state IDLE. `req_ready` is 1 while reset is deasserted and state is IDLE.
- `req_ready = (state==IDLE) || (out_valid && out_ready && out_last)`. Combinational from `out_ready`; no dependency on `req_valid`.
- Latency: accept in cycle N → word 0 registered, `out_valid`=1 in N+1. Word 1 appears the cycle after word 0 is consumed.
- Throughput: one word/cycle under continuous `out_ready`. Back-to-back single-word requests sustain 1/cycle.
- `out_*` are held stable while `out_valid && !out_ready`.
- Reset mid-request: the partial sequence is dropped, with no word 1 after reset.
- `out_err` is valid with every word of the offending request. LI never sets it.

## Structure
- `isa_pkg` holds:
  - opcode localparams: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, CALCI, CALC, FLOAD, FSTORE, F, FBRANCH, VLW, VSW, FLI;
  - the format enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_FLI};
  - the ADDI funct3 constant.
- One combinational sub-module, `imm_pack`: format + fields + imm → word and range error. It is reused for word 0 and for the LI second word.
- Top level holds the FSM, request latch and output register.

## Test plan
- BRANCH, rs1=1, rs2=2, funct3=0, imm=-4 → `out_instr`=0xFE208EE3, `out_last`=1, `out_err`=0, one cycle after accept.
- FLI rd=5, imm=0x40490FDB, with `out_ready` stalled 3 cycles on word 0 → words 0x404902C4 then 0x00FDB000. Word 0 stays stable during the stall; `out_last` set only on word 1.
- LI rd=10, imm=0x12345FFF → 0x12346537 (LUI) then 0xFFF50513 (ADDI). LI imm=-1 → single 0xFFF00513.
- CALCI imm=2048 → `out_err`=1, imm field truncated to 0x800. JAL imm=3 → `out_err`=1.
- 8 back-to-back single-word requests with `out_ready`=1 → 8 words on 8 consecutive cycles, `req_ready` continuously 1.
- Assert `rstn`=0 while an FLI is in EMIT1 → `out_valid`=0 immediately. After release, the next request's word 0 is the first word emitted.

Source files
------------

// File: rtl/isa_pkg.sv
// Opcode map, instruction format enum and the opcode-to-format lookup shared by
// the instruction encoder and its immediate packer.
package isa_pkg;

  localparam logic [6:0] LUI     = 7'h37;
  localparam logic [6:0] AUIPC   = 7'h17;
  localparam logic [6:0] JAL     = 7'h6F;
  localparam logic [6:0] JALR    = 7'h67;
  localparam logic [6:0] BRANCH  = 7'h63;
  localparam logic [6:0] LOAD    = 7'h03;
  localparam logic [6:0] STORE   = 7'h23;
  localparam logic [6:0] CALCI   = 7'h13;
  localparam logic [6:0] CALC    = 7'h33;
  localparam logic [6:0] FLOAD   = 7'h07;
  localparam logic [6:0] FSTORE  = 7'h27;
  localparam logic [6:0] F       = 7'h53;
  localparam logic [6:0] FBRANCH = 7'h5B;
  localparam logic [6:0] VLW     = 7'h0B;
  localparam logic [6:0] VSW     = 7'h2B;
  localparam logic [6:0] FLI     = 7'h44;

  localparam logic [2:0] ADDI_F3 = 3'b000;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_FLI} fmt_e;

  function automatic fmt_e opcode_fmt(input logic [6:0] op);
    case (op)
      LUI, AUIPC:                          return FMT_U;
      JAL:                                 return FMT_J;
      JALR, LOAD, CALCI, FLOAD, VLW, VSW:  return FMT_I;
      STORE, FSTORE:                       return FMT_S;
      BRANCH, FBRANCH:                     return FMT_B;
      FLI:                                 return FMT_FLI;
      default:                             return FMT_R;
    endcase
  endfunction

  function automatic logic opcode_known(input logic [6:0] op);
    case (op)
      LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, CALCI,
      CALC, FLOAD, FSTORE, F, FBRANCH, VLW, VSW, FLI: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: places register fields and the immediate into one
// 32-bit word for the given format and flags immediates the format cannot hold.
module imm_pack
  import isa_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  logic fits12, fits13, fits21;

  // Sign-fit tests: every bit above the field's sign bit must copy it.
  assign fits12 = (&imm[31:11]) || (~|imm[31:11]);
  assign fits13 = (&imm[31:12]) || (~|imm[31:12]);
  assign fits21 = (&imm[31:20]) || (~|imm[31:20]);

  always_comb begin
    instr = {funct7, rs2, rs1, funct3, rd, opcode};
    err   = 1'b0;
    case (fmt)
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = !fits12;
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = !fits12;
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = !fits13 || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = |imm[11:0];
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = !fits21 || imm[0];
      end
      FMT_FLI: begin
        instr = {imm[31:12], rd, opcode};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32 instruction encoder: turns field-level requests into packed
// instruction words, sequencing the two-word FLI and split LI cases.
module instr_encoder
  import isa_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_opcode,
  input  logic        req_li,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, EMIT0, EMIT1} state_e;

  state_e      state, state_nxt;
  logic        consume, accept;
  logic        li_fits12, two_word0, err0, err0_pack;
  fmt_e        fmt0;
  logic [6:0]  op0;
  logic [4:0]  rs1_0;
  logic [2:0]  f3_0;
  logic [31:0] imm0, word0;
  logic        lat_li, lat_err;
  logic [4:0]  lat_rd;
  logic [11:0] lat_lo;
  logic [31:0] addi_word, word1;
  logic        err1, err1_pack;

  assign consume   = out_valid && out_ready;
  assign req_ready = (state == IDLE) || (consume && out_last);
  assign accept    = req_valid && req_ready;
  assign out_valid = (state != IDLE);

  // LI picks between a single ADDI and a LUI whose upper part absorbs the
  // sign of the low 12 bits that the following ADDI will add back.
  always_comb begin
    li_fits12 = (&req_imm[31:11]) || (~|req_imm[31:11]);
    fmt0      = opcode_fmt(req_opcode);
    op0       = req_opcode;
    rs1_0     = req_rs1;
    f3_0      = req_funct3;
    imm0      = req_imm;
    if (req_li) begin
      rs1_0 = 5'd0;
      f3_0  = ADDI_F3;
      if (li_fits12) begin
        fmt0 = FMT_I;
        op0  = CALCI;
      end else begin
        fmt0 = FMT_U;
        op0  = LUI;
        imm0 = {req_imm[31:12] + 20'(req_imm[11]), 12'h000};
      end
    end
  end

  assign two_word0 = req_li ? !li_fits12 : (req_opcode == FLI);
  assign err0      = !req_li && (err0_pack || !opcode_known(req_opcode));

  imm_pack u_pack0 (
    .fmt    (fmt0),
    .opcode (op0),
    .rd     (req_rd),
    .rs1    (rs1_0),
    .rs2    (req_rs2),
    .funct3 (f3_0),
    .funct7 (req_funct7),
    .imm    (imm0),
    .instr  (word0),
    .err    (err0_pack)
  );

  imm_pack u_pack1 (
    .fmt    (FMT_I),
    .opcode (CALCI),
    .rd     (lat_rd),
    .rs1    (lat_rd),
    .rs2    (5'd0),
    .funct3 (ADDI_F3),
    .funct7 (7'd0),
    .imm    ({{20{lat_lo[11]}}, lat_lo}),
    .instr  (addi_word),
    .err    (err1_pack)
  );

  assign word1 = lat_li ? addi_word : {8'h00, lat_lo, 12'h000};
  assign err1  = lat_err || (lat_li && err1_pack);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = EMIT0;
      EMIT0: if (consume) begin
        if (!out_last)   state_nxt = EMIT1;
        else if (accept) state_nxt = EMIT0;
        else             state_nxt = IDLE;
      end
      EMIT1: if (consume) state_nxt = accept ? EMIT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A new accept always loads word 0; word 1 is built purely from the latch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_instr <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      lat_li    <= 1'b0;
      lat_err   <= 1'b0;
      lat_rd    <= '0;
      lat_lo    <= '0;
    end else if (accept) begin
      out_instr <= word0;
      out_last  <= !two_word0;
      out_err   <= err0;
      lat_li    <= req_li;
      lat_err   <= err0;
      lat_rd    <= req_rd;
      lat_lo    <= req_imm[11:0];
    end else if ((state == EMIT0) && consume && !out_last) begin
      out_instr <= word1;
      out_last  <= 1'b1;
      out_err   <= err1;
    end
  end

endmodule
